// File: rtl/fifo_if.sv
// Purpose : signal bundle for the synchronous FIFO; the environment drives clk and rst.
// Ports   : clk, rst, wr_en, wdata, rd_en (into the FIFO); rdata, full_flag, empty_flag (out of it).
// Modports: dut (FIFO side), tb (environment side, directions mirrored).
interface fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             full_flag;
  logic             empty_flag;

  modport dut (
    input  clk,
    input  rst,
    input  wr_en,
    input  wdata,
    input  rd_en,
    output rdata,
    output full_flag,
    output empty_flag
  );

  modport tb (
    output clk,
    output rst,
    output wr_en,
    output wdata,
    output rd_en,
    input  rdata,
    input  full_flag,
    input  empty_flag
  );

endinterface

// File: rtl/fifo.sv
// Purpose : single-clock FIFO of DEPTH words x WIDTH bits with registered read data.
// Latency : rdata updates on the edge that accepts rd_en (one cycle); flags follow the registered count.
// Backpr. : writes while full and reads while empty are dropped; rdata holds when no read is accepted.
// Ports   : fifo_intf (fifo_if.dut) -- clk, async active-high rst, wr_en/wdata, rd_en, rdata,
//           full_flag, empty_flag.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  fifo_if.dut fifo_intf
);

  localparam int AW = $clog2(DEPTH);

  // The interface instance carries its own sizes; they must agree with ours,
  // and the pointer arithmetic below relies on DEPTH being a power of two.
  if ((fifo_intf.WIDTH != WIDTH) || (fifo_intf.DEPTH != DEPTH)) begin : g_size_mismatch
    $error("fifo: interface WIDTH/DEPTH differ from module parameters");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo: DEPTH must be a power of two and at least 2");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] rdata_q;

  // --------------------------------------------------------------------------
  // Acceptance: decided purely from the registered count, so the flags never
  // depend combinationally on wr_en/rd_en. A full FIFO still accepts a read
  // and an empty one still accepts a write in the same cycle.
  // --------------------------------------------------------------------------
  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;

  assign full_w  = (count == (AW+1)'(DEPTH));
  assign empty_w = (count == '0);
  assign wr_acc  = fifo_intf.wr_en & ~full_w;
  assign rd_acc  = fifo_intf.rd_en & ~empty_w;

  // --------------------------------------------------------------------------
  // Next-state logic for pointers and occupancy
  // --------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count_nxt;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;

    // AW-bit pointers wrap from DEPTH-1 to 0 on their own.
    if (wr_acc) begin
      wr_ptr_nxt = wr_ptr + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_nxt = rd_ptr + AW'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers: cleared asynchronously; reset discards all contents by
  // zeroing the pointers and count.
  // --------------------------------------------------------------------------
  always_ff @(posedge fifo_intf.clk or posedge fifo_intf.rst) begin
    if (fifo_intf.rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (rd_acc) begin
        rdata_q <= mem[rd_ptr];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage array: no reset. Stale words are unreachable because count is
  // zero after reset; writes are blocked while rst is high so a write in
  // flight during reset cannot land.
  // --------------------------------------------------------------------------
  always_ff @(posedge fifo_intf.clk) begin
    if (wr_acc && !fifo_intf.rst) begin
      mem[wr_ptr] <= fifo_intf.wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fifo_intf.rdata      = rdata_q;
  assign fifo_intf.full_flag  = full_w;
  assign fifo_intf.empty_flag = empty_w;

  // --------------------------------------------------------------------------
  // Invariants
  // --------------------------------------------------------------------------
  a_count_range : assert property (
    @(posedge fifo_intf.clk) disable iff (fifo_intf.rst)
      count <= (AW+1)'(DEPTH)
  );

  a_flags_exclusive : assert property (
    @(posedge fifo_intf.clk) disable iff (fifo_intf.rst)
      !(full_w && empty_w)
  );

  a_ptr_distance : assert property (
    @(posedge fifo_intf.clk) disable iff (fifo_intf.rst)
      (wr_ptr - rd_ptr) == count[AW-1:0]
  );

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  localparam int W = 32;
  localparam int D = 8;

  fifo_if #(.WIDTH(W), .DEPTH(D)) intf ();

  fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .fifo_intf(intf)
  );

  initial intf.clk = 1'b0;
  always #5 intf.clk = ~intf.clk;

  // Reference model: stored words in order, plus the last word read out.
  logic [W-1:0] q[$];
  logic [W-1:0] exp_rdata;

  int vectors;
  int miscompares;

  // One clock cycle of stimulus. Inputs change 1 time unit after a rising
  // edge; the model applies the FIFO rules to the state before the edge and
  // the caller samples outputs 1 time unit after the edge.
  task automatic cycle(input logic we, input logic [W-1:0] wd, input logic re);
    bit wacc;
    bit racc;
    intf.wr_en = we;
    intf.wdata = wd;
    intf.rd_en = re;
    @(posedge intf.clk);
    if (intf.rst) begin
      q.delete();
      exp_rdata = '0;
    end else begin
      wacc = we && (q.size() < D);
      racc = re && (q.size() > 0);
      if (racc) exp_rdata = q.pop_front();
      if (wacc) q.push_back(wd);
    end
    #1;
  endtask

  task automatic test_reset();
    intf.rst   = 1'b1;
    intf.wr_en = 1'b0;
    intf.rd_en = 1'b0;
    intf.wdata = '0;
    q.delete();
    exp_rdata = '0;
    // Requests during reset must be ignored.
    cycle(1'b1, 32'h1234_5678, 1'b0);
    cycle(1'b1, 32'h1111_1111, 1'b1);
    vectors++;
    if (intf.rdata !== 32'h0 || intf.empty_flag !== 1'b1 || intf.full_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: rdata=%h empty=%b full=%b, want rdata=00000000 empty=1 full=0",
               intf.rdata, intf.empty_flag, intf.full_flag);
    end
    intf.rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [W-1:0] pat;
    for (int i = 0; i < D; i++) begin
      pat = (i % 2 == 0) ? 32'hD4F4_0099 : 32'h281B_86C4;
      cycle(1'b1, pat, 1'b0);
      vectors++;
      if (intf.empty_flag !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_empty[%0d]: empty=%b want 0", i, intf.empty_flag);
      end
      vectors++;
      if (intf.full_flag !== (i == D - 1)) begin
        miscompares++;
        $display("FAIL fill_full[%0d]: full=%b want %b", i, intf.full_flag, (i == D - 1));
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hBABA_BABA, 1'b0);
      vectors++;
      if (intf.full_flag !== 1'b1 || intf.empty_flag !== 1'b0 || q.size() != D) begin
        miscompares++;
        $display("FAIL overflow[%0d]: full=%b empty=%b model_count=%0d, want full=1 empty=0 count=%0d",
                 i, intf.full_flag, intf.empty_flag, q.size(), D);
      end
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] want;
    for (int i = 0; i < D; i++) begin
      want = (i % 2 == 0) ? 32'hD4F4_0099 : 32'h281B_86C4;
      cycle(1'b0, '0, 1'b1);
      vectors++;
      if (intf.rdata !== want || intf.rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL drain_rdata[%0d]: rdata=%h want %h", i, intf.rdata, want);
      end
      vectors++;
      if (intf.full_flag !== 1'b0 || intf.empty_flag !== (i == D - 1)) begin
        miscompares++;
        $display("FAIL drain_flags[%0d]: full=%b empty=%b want full=0 empty=%b",
                 i, intf.full_flag, intf.empty_flag, (i == D - 1));
      end
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      vectors++;
      if (intf.rdata !== 32'h281B_86C4 || intf.empty_flag !== 1'b1 || intf.full_flag !== 1'b0) begin
        miscompares++;
        $display("FAIL underflow[%0d]: rdata=%h empty=%b full=%b want rdata=281b86c4 empty=1 full=0",
                 i, intf.rdata, intf.empty_flag, intf.full_flag);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    cycle(1'b1, 32'h7654_3210, 1'b0);
    // Assert reset between edges while a write is being presented.
    intf.wr_en = 1'b1;
    intf.wdata = 32'hFFFF_FFFF;
    intf.rst   = 1'b1;
    #1;
    vectors++;
    if (intf.empty_flag !== 1'b1 || intf.full_flag !== 1'b0 || intf.rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: rdata=%h empty=%b full=%b want rdata=00000000 empty=1 full=0",
               intf.rdata, intf.empty_flag, intf.full_flag);
    end
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
    intf.rst = 1'b0;
    cycle(1'b1, 32'h89AB_CDEF, 1'b0);
    for (int i = 0; i < D; i++) begin
      cycle(1'b0, '0, 1'b1);
      vectors++;
      if (intf.rdata !== 32'h89AB_CDEF) begin
        miscompares++;
        $display("FAIL reset_mid_read[%0d]: rdata=%h want 89abcdef", i, intf.rdata);
      end
    end
    vectors++;
    if (intf.empty_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_empty: empty=%b want 1", intf.empty_flag);
    end
  endtask

  task automatic test_wrap_concurrent();
    logic [W-1:0] next_wd;
    logic [W-1:0] next_rd;
    next_wd = 32'h0000_1000;
    next_rd = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, next_wd, 1'b0);
      next_wd++;
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, next_wd, 1'b1);
      next_wd++;
      vectors++;
      if (intf.rdata !== next_rd) begin
        miscompares++;
        $display("FAIL wrap_rdata[%0d]: rdata=%h want %h", i, intf.rdata, next_rd);
      end
      next_rd++;
      vectors++;
      if (intf.full_flag !== 1'b0 || intf.empty_flag !== 1'b0 || q.size() != 4) begin
        miscompares++;
        $display("FAIL wrap_flags[%0d]: full=%b empty=%b model_count=%0d want 0 0 4",
                 i, intf.full_flag, intf.empty_flag, q.size());
      end
    end
  endtask

  task automatic test_random();
    logic         we;
    logic         re;
    logic [W-1:0] wd;
    for (int i = 0; i < 600; i++) begin
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      wd = $urandom();
      intf.rst = ($urandom_range(0, 99) == 0);
      cycle(we, wd, re);
      intf.rst = 1'b0;
      vectors++;
      if (intf.rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL rand_rdata[%0d]: rdata=%h want %h", i, intf.rdata, exp_rdata);
      end
      vectors++;
      if (intf.full_flag !== (q.size() == D) || intf.empty_flag !== (q.size() == 0)) begin
        miscompares++;
        $display("FAIL rand_flags[%0d]: full=%b empty=%b model_count=%0d",
                 i, intf.full_flag, intf.empty_flag, q.size());
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_reset_mid_write();
    test_wrap_concurrent();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
